// File: rtl/char_pixel_reader_if.sv
// Signal bundle for char_pixel_reader: incoming video timing, the BRAM read port and
// the re-aligned pixel output. Directions in the slave modport are as seen by the reader.
interface char_pixel_reader_if #(
  parameter int MEMWIDTH = 20
);
  logic                de_i;
  logic                hs_i;
  logic                vs_i;
  logic [MEMWIDTH-1:0] raddr_o;
  logic                rdata_i;
  logic                de_o;
  logic                hs_o;
  logic                vs_o;
  logic [23:0]         rgb_o;

  modport master (
    output de_i, hs_i, vs_i, rdata_i,
    input  raddr_o, de_o, hs_o, vs_o, rgb_o
  );

  modport slave (
    input  de_i, hs_i, vs_i, rdata_i,
    output raddr_o, de_o, hs_o, vs_o, rgb_o
  );
endinterface

// File: rtl/char_pixel_reader.sv
// Renders a 1-bit row-major BRAM bitmap inside a fixed text window into an RGB888 stream,
// re-aligning colour and de/hs/vs across the 2-clock BRAM read pipeline.
//
//   state       | meaning
//   ST_WAIT_VS  | after reset; no complete frame seen yet, window forced to background
//   ST_RUN      | a vsync has been seen; window pixels come from the bitmap
module char_pixel_reader #(
  parameter int          MEMWIDTH = 20,
  parameter int          WIN_X0   = 0,
  parameter int          WIN_Y0   = 0,
  parameter int          WIN_W    = 64,
  parameter int          WIN_H    = 16,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  parameter bit          VS_POL   = 1'b1
) (
  input logic                clk,
  input logic                rst,
  char_pixel_reader_if.slave bus
);

  localparam int CW = 16;

  typedef enum logic {ST_WAIT_VS, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       x_cnt_q, x_cnt_d;
  logic [CW-1:0]       y_cnt_q, y_cnt_d;
  logic [MEMWIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [MEMWIDTH-1:0] raddr_q, raddr_d;
  logic                win_d1_q, win_d1_d;
  logic                win_d2_q, win_d2_d;
  logic [2:0]          tim1_q, tim1_d;
  logic [2:0]          tim2_q, tim2_d;
  logic [2:0]          tim_out_q, tim_out_d;
  logic [23:0]         rgb_q, rgb_d;

  logic vs_act;
  logic x_in;
  logic y_in;
  logic in_win;
  logic frame_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_VS;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      addr_cnt_q <= '0;
      raddr_q    <= '0;
      win_d1_q   <= 1'b0;
      win_d2_q   <= 1'b0;
      tim1_q     <= '0;
      tim2_q     <= '0;
      tim_out_q  <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      raddr_q    <= raddr_d;
      win_d1_q   <= win_d1_d;
      win_d2_q   <= win_d2_d;
      tim1_q     <= tim1_d;
      tim2_q     <= tim2_d;
      tim_out_q  <= tim_out_d;
      rgb_q      <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vs_act  = (bus.vs_i == VS_POL);
    case (state_q)
      ST_WAIT_VS: if (vs_act) state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_WAIT_VS;
    endcase
    frame_ok = (state_q == ST_RUN);

    // Window test uses counter values from before this edge; a vsync pixel never qualifies.
    x_in   = (int'(x_cnt_q) >= WIN_X0) && (int'(x_cnt_q) < WIN_X0 + WIN_W);
    y_in   = (int'(y_cnt_q) >= WIN_Y0) && (int'(y_cnt_q) < WIN_Y0 + WIN_H);
    in_win = bus.de_i & ~vs_act & x_in & y_in;

    x_cnt_d = bus.de_i ? x_cnt_q + CW'(1) : '0;

    y_cnt_d = y_cnt_q;
    if (vs_act)
      y_cnt_d = '0;
    else if (tim1_q[2] && !bus.de_i)
      y_cnt_d = y_cnt_q + CW'(1);

    addr_cnt_d = addr_cnt_q;
    if (vs_act)
      addr_cnt_d = '0;
    else if (in_win)
      addr_cnt_d = addr_cnt_q + MEMWIDTH'(1);

    raddr_d  = in_win ? addr_cnt_q : raddr_q;
    win_d1_d = in_win & frame_ok;
    tim1_d   = {bus.de_i, bus.hs_i, bus.vs_i};

    win_d2_d = win_d1_q;
    tim2_d   = tim1_q;

    tim_out_d = tim2_q;
    if (!tim2_q[2])
      rgb_d = '0;
    else if (win_d2_q && bus.rdata_i)
      rgb_d = FG_COLOR;
    else
      rgb_d = BG_COLOR;
  end

  assign bus.raddr_o = raddr_q;
  assign bus.de_o    = tim_out_q[2];
  assign bus.hs_o    = tim_out_q[1];
  assign bus.vs_o    = tim_out_q[0];
  assign bus.rgb_o   = rgb_q;

endmodule

// File: tb/tb_char_pixel_reader.sv
// Directed bench: two reader instances share one 128x32 timing stream; the first uses
// an offset window on a 20-bit BRAM, the second a 512-entry BRAM that wraps mid-window.
module tb_char_pixel_reader;

  localparam logic [23:0] FG_A = 24'hFFFFFF;
  localparam logic [23:0] BG_A = 24'h123456;
  localparam logic [23:0] FG_B = 24'hFFFFFF;
  localparam logic [23:0] BG_B = 24'h000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  char_pixel_reader_if #(.MEMWIDTH(20)) bus_a ();
  char_pixel_reader_if #(.MEMWIDTH(9))  bus_b ();

  char_pixel_reader #(
    .MEMWIDTH(20), .WIN_X0(8), .WIN_Y0(4), .WIN_W(64), .WIN_H(16),
    .FG_COLOR(FG_A), .BG_COLOR(BG_A), .VS_POL(1'b1)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a.slave)
  );

  char_pixel_reader #(
    .MEMWIDTH(9), .WIN_X0(0), .WIN_Y0(0), .WIN_W(64), .WIN_H(16),
    .FG_COLOR(FG_B), .BG_COLOR(BG_B), .VS_POL(1'b1)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b.slave)
  );

  // Bitmap contents: pat 0 = all ones, pat 1 = alternating starting with 1 at address 0.
  int pat;

  function automatic logic bit_a(input int a);
    return (pat == 0) ? 1'b1 : ((a % 2) == 0);
  endfunction

  function automatic logic bit_b(input int a);
    return (a % 3) == 0;
  endfunction

  always @(posedge clk) begin
    bus_a.rdata_i <= bit_a(int'(bus_a.raddr_o));
    bus_b.rdata_i <= bit_b(int'(bus_b.raddr_o));
  end

  int n_tests;
  int n_fail;

  logic [26:0] p1_a, p2_a, p1_b, p2_b;
  bit          fok_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one pixel, advance one clock and compare both outputs with the pixel of two clocks ago.
  task automatic step(input logic de, input logic hs, input logic vs, input logic r,
                      input int x, input int y);
    logic [26:0] cur_a, cur_b, ea, eb;
    logic [23:0] c_a, c_b;
    bit          inw_a, inw_b;
    int          ad_a, ad_b;

    rst        = r;
    bus_a.de_i = de;
    bus_a.hs_i = hs;
    bus_a.vs_i = vs;
    bus_b.de_i = de;
    bus_b.hs_i = hs;
    bus_b.vs_i = vs;

    inw_a = de && !vs && x >= 8 && x < 72 && y >= 4 && y < 20;
    ad_a  = (y - 4) * 64 + (x - 8);
    if (!de)                                c_a = 24'h0;
    else if (inw_a && fok_m && bit_a(ad_a)) c_a = FG_A;
    else                                    c_a = BG_A;
    cur_a = {de, hs, vs, c_a};

    inw_b = de && !vs && x >= 0 && x < 64 && y >= 0 && y < 16;
    ad_b  = (y * 64 + x) % 512;
    if (!de)                                c_b = 24'h0;
    else if (inw_b && fok_m && bit_b(ad_b)) c_b = FG_B;
    else                                    c_b = BG_B;
    cur_b = {de, hs, vs, c_b};

    @(posedge clk);
    #1;
    if (r) begin
      ea = '0; eb = '0;
      p1_a = '0; p2_a = '0; p1_b = '0; p2_b = '0;
      fok_m = 1'b0;
    end else begin
      ea = p2_a; p2_a = p1_a; p1_a = cur_a;
      eb = p2_b; p2_b = p1_b; p1_b = cur_b;
      if (vs) fok_m = 1'b1;
    end

    check_eq("out_a", {5'b0, bus_a.de_o, bus_a.hs_o, bus_a.vs_o, bus_a.rgb_o}, {5'b0, ea});
    check_eq("out_b", {5'b0, bus_b.de_o, bus_b.hs_o, bus_b.vs_o, bus_b.rgb_o}, {5'b0, eb});
    if (r) begin
      check_eq("rst_raddr_a", 32'(bus_a.raddr_o), 32'd0);
      check_eq("rst_raddr_b", 32'(bus_b.raddr_o), 32'd0);
    end
  endtask

  // One frame: a vsync line (first cycle with de high too), then 32 lines of 128 pixels.
  task automatic frame(input bit rst_mid, input bit chk_addr);
    step(1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 128; x++) begin
        step(1'b1, 1'b0, 1'b0, rst_mid && y == 10 && (x == 40 || x == 41), x, y);
        if (chk_addr) begin
          if (x == 8  && y == 4)  check_eq("raddr_a_8_4",   32'(bus_a.raddr_o), 32'd0);
          if (x == 9  && y == 4)  check_eq("raddr_a_9_4",   32'(bus_a.raddr_o), 32'd1);
          if (x == 8  && y == 5)  check_eq("raddr_a_8_5",   32'(bus_a.raddr_o), 32'd64);
          if (x == 71 && y == 19) check_eq("raddr_a_last",  32'(bus_a.raddr_o), 32'd1023);
          if (x == 63 && y == 7)  check_eq("raddr_b_63_7",  32'(bus_b.raddr_o), 32'd511);
          if (x == 0  && y == 8)  check_eq("raddr_b_wrap",  32'(bus_b.raddr_o), 32'd0);
          if (x == 1  && y == 8)  check_eq("raddr_b_after", 32'(bus_b.raddr_o), 32'd1);
        end
      end
      for (int h = 0; h < 8; h++)
        step(1'b0, (h >= 2 && h < 6), 1'b0, 1'b0, -1, y);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fok_m   = 1'b0;
    pat     = 0;
    p1_a = '0; p2_a = '0; p1_b = '0; p2_b = '0;

    for (int i = 0; i < 3; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b1, -1, -1);

    // Active pixels before any vsync must stay background.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, i, 0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);

    pat = 0; frame(1'b0, 1'b1);
    pat = 1; frame(1'b0, 1'b1);
    frame(1'b1, 1'b0);
    pat = 0; frame(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
